// File: rtl/dmem_arbiter_if.sv
// Requester-side bundle for the data-memory arbiter: core port (c_*) and DMA/debug port (d_*).
// The slave modport is the arbiter's view. The master modport is the requesters' view.
interface dmem_arbiter_if #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
);
  logic                  c_req, c_we, c_gnt, c_rvalid, c_err;
  logic [DM_ADDRESS-1:0] c_addr;
  logic [DATA_W-1:0]     c_wdata, c_rdata;
  logic [2:0]            c_funct3;

  logic                  d_req, d_we, d_gnt, d_rvalid, d_err;
  logic [DM_ADDRESS-1:0] d_addr;
  logic [DATA_W-1:0]     d_wdata, d_rdata;
  logic [2:0]            d_funct3;

  modport slave (
    input  c_req, c_we, c_addr, c_wdata, c_funct3,
    output c_gnt, c_rvalid, c_rdata, c_err,
    input  d_req, d_we, d_addr, d_wdata, d_funct3,
    output d_gnt, d_rvalid, d_rdata, d_err
  );

  modport master (
    output c_req, c_we, c_addr, c_wdata, c_funct3,
    input  c_gnt, c_rvalid, c_rdata, c_err,
    output d_req, d_we, d_addr, d_wdata, d_funct3,
    input  d_gnt, d_rvalid, d_rdata, d_err
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: the core has fixed priority, and a wait counter forces a DMA grant.
// It also checks access legality and returns a registered response one cycle after each grant.
module dmem_arbiter #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32,
  parameter int MAX_WAIT   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  dmem_arbiter_if.slave         bus,
  output logic                  MemRead,
  output logic                  MemWrite,
  output logic [DM_ADDRESS-1:0] a,
  output logic [DATA_W-1:0]     wd,
  output logic [2:0]            Funct3,
  input  logic [DATA_W-1:0]     rd
);
  localparam int CW = $clog2(MAX_WAIT + 1);

  logic [CW-1:0]         wait_cnt_reg;
  logic                  force_d, c_gnt, d_gnt, gnt_any;
  logic [1:0]            gnt;
  logic                  we_sel, legal_sel;
  logic [DM_ADDRESS-1:0] addr_sel;
  logic [DATA_W-1:0]     wdata_sel;
  logic [2:0]            funct3_sel;

  function automatic logic legal_f(input logic we, input logic [2:0] f3, input logic [1:0] lo);
    logic ok;
    case (f3)
      3'b000:  ok = 1'b1;
      3'b001:  ok = !lo[0];
      3'b010:  ok = (lo == 2'b00);
      3'b100:  ok = !we;
      3'b101:  ok = !we && !lo[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  assign force_d = bus.d_req && (wait_cnt_reg == CW'(MAX_WAIT));
  assign d_gnt   = !reset && bus.d_req && (!bus.c_req || force_d);
  assign c_gnt   = !reset && bus.c_req && !d_gnt;
  assign gnt_any = c_gnt || d_gnt;
  assign gnt     = {d_gnt, c_gnt};

  assign bus.c_gnt = c_gnt;
  assign bus.d_gnt = d_gnt;

  // Only one port can be granted, so a single selected payload feeds memory and the response.
  assign we_sel     = d_gnt ? bus.d_we     : bus.c_we;
  assign addr_sel   = d_gnt ? bus.d_addr   : bus.c_addr;
  assign wdata_sel  = d_gnt ? bus.d_wdata  : bus.c_wdata;
  assign funct3_sel = d_gnt ? bus.d_funct3 : bus.c_funct3;
  assign legal_sel  = legal_f(we_sel, funct3_sel, addr_sel[1:0]);

  assign MemRead  = gnt_any && !we_sel && legal_sel;
  assign MemWrite = gnt_any &&  we_sel && legal_sel;
  assign a        = gnt_any ? addr_sel   : '0;
  assign wd       = gnt_any ? wdata_sel  : '0;
  assign Funct3   = gnt_any ? funct3_sel : 3'b000;

  always_ff @(posedge clk) begin
    if (reset)
      wait_cnt_reg <= '0;
    else if (!bus.d_req || d_gnt)
      wait_cnt_reg <= '0;
    else if (wait_cnt_reg != CW'(MAX_WAIT))
      wait_cnt_reg <= wait_cnt_reg + 1'b1;
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    logic              rvalid_reg, err_reg;
    logic [DATA_W-1:0] rdata_reg;

    always_ff @(posedge clk) begin
      if (reset) begin
        rvalid_reg <= 1'b0;
        err_reg    <= 1'b0;
        rdata_reg  <= '0;
      end else begin
        rvalid_reg <= gnt[gi];
        err_reg    <= gnt[gi] && !legal_sel;
        rdata_reg  <= (gnt[gi] && legal_sel && !we_sel) ? rd : '0;
      end
    end
  end

  // Masking with reset drops a response that was registered in the cycle before reset rose.
  assign bus.c_rvalid = g_port[0].rvalid_reg && !reset;
  assign bus.c_err    = g_port[0].err_reg && !reset;
  assign bus.c_rdata  = reset ? '0 : g_port[0].rdata_reg;
  assign bus.d_rvalid = g_port[1].rvalid_reg && !reset;
  assign bus.d_err    = g_port[1].err_reg && !reset;
  assign bus.d_rdata  = reset ? '0 : g_port[1].rdata_reg;
endmodule
